// File: rtl/vga_sync_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vga_sync_rx : recovers VGA raster timing from h/v sync, locks, and       |
// |               emits active-area pixels with coordinates.  Rev 1.0        |
// +--------------------------------------------------------------------------+
module vga_sync_rx #(
   parameter int PIXEL_BITS  = 4,
   parameter int H_COUNT_MAX = 800,
   parameter int V_COUNT_MAX = 525,
   parameter int H_ACT_START = 144,
   parameter int H_ACT_END   = 784,
   parameter int V_ACT_START = 35,
   parameter int V_ACT_END   = 515,
   parameter int LOCK_FRAMES = 2,
   parameter int H_BITS      = $clog2(H_COUNT_MAX),
   parameter int V_BITS      = $clog2(V_COUNT_MAX)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  pix_en,
   input  logic                  h_sync,
   input  logic                  v_sync,
   input  logic [PIXEL_BITS-1:0] vga_r,
   input  logic [PIXEL_BITS-1:0] vga_g,
   input  logic [PIXEL_BITS-1:0] vga_b,
   output logic                  rx_valid,
   output logic [H_BITS-1:0]     rx_x,
   output logic [V_BITS-1:0]     rx_y,
   output logic [PIXEL_BITS-1:0] rx_r,
   output logic [PIXEL_BITS-1:0] rx_g,
   output logic [PIXEL_BITS-1:0] rx_b,
   output logic                  frame_start,
   output logic                  locked,
   output logic                  sync_err
);

   localparam int G_BITS = $clog2(LOCK_FRAMES + 1);

   localparam logic [H_BITS-1:0] c_h_last      = H_BITS'(H_COUNT_MAX - 1);
   localparam logic [V_BITS-1:0] c_v_last      = V_BITS'(V_COUNT_MAX - 1);
   localparam logic [H_BITS-1:0] c_h_act_start = H_BITS'(H_ACT_START);
   localparam logic [V_BITS-1:0] c_v_act_start = V_BITS'(V_ACT_START);
   localparam logic [H_BITS:0]   c_h_act_end   = (H_BITS+1)'(H_ACT_END);
   localparam logic [V_BITS:0]   c_v_act_end   = (V_BITS+1)'(V_ACT_END);
   localparam logic [G_BITS-1:0] c_lock_frames = G_BITS'(LOCK_FRAMES);

   localparam logic [1:0] S_SEARCH = 2'd0;
   localparam logic [1:0] S_TRACK  = 2'd1;
   localparam logic [1:0] S_LOCKED = 2'd2;

   logic [H_BITS-1:0] r_h_count, w_h_next;
   logic [V_BITS-1:0] r_v_count, w_v_next;
   logic              r_prev_h, r_prev_v;
   logic [1:0]        r_state, w_state_next;
   logic [G_BITS-1:0] r_good_cnt, w_good_next, w_good_inc;
   logic              w_h_edge, w_v_edge, w_line_err, w_frame_err, w_err;
   logic              w_fs, w_serr, w_active, w_valid;

   always_comb begin
      w_h_edge    = r_prev_h & ~h_sync;
      w_v_edge    = r_prev_v & ~v_sync;

      w_h_next    = (w_h_edge || (r_h_count == c_h_last)) ? '0 : r_h_count + 1'b1;
      if (w_v_edge)
         w_v_next = '0;
      else if (w_h_edge && (r_v_count != c_v_last))
         w_v_next = r_v_count + 1'b1;
      else
         w_v_next = r_v_count;

      // An edge off the last column, or reaching the last column without an edge.
      w_line_err  = w_h_edge ? (r_h_count != c_h_last) : (r_h_count == c_h_last);
      w_frame_err = w_v_edge & (r_v_count != c_v_last);
      w_err       = w_line_err | w_frame_err;

      w_state_next = r_state;
      w_good_next  = r_good_cnt;
      w_good_inc   = r_good_cnt + 1'b1;
      w_fs         = 1'b0;
      w_serr       = 1'b0;
      case (r_state)
         S_SEARCH: begin
            if (w_v_edge) begin
               w_state_next = S_TRACK;
               w_good_next  = '0;
            end
         end
         S_TRACK: begin
            if (w_err) begin
               w_state_next = S_SEARCH;
               w_serr       = 1'b1;
            end else if (w_v_edge) begin
               w_good_next = w_good_inc;
               if (w_good_inc == c_lock_frames) begin
                  w_state_next = S_LOCKED;
                  w_fs         = 1'b1;
               end
            end
         end
         S_LOCKED: begin
            if (w_err) begin
               w_state_next = S_SEARCH;
               w_serr       = 1'b1;
            end else if (w_v_edge) begin
               w_fs = 1'b1;
            end
         end
         default: w_state_next = S_SEARCH;
      endcase

      w_active = (w_h_next >= c_h_act_start) && ({1'b0, w_h_next} < c_h_act_end) &&
                 (w_v_next >= c_v_act_start) && ({1'b0, w_v_next} < c_v_act_end);
      w_valid  = w_active && (w_state_next == S_LOCKED);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_h_count   <= '0;
         r_v_count   <= '0;
         r_good_cnt  <= '0;
         r_prev_h    <= 1'b1;
         r_prev_v    <= 1'b1;
         r_state     <= S_SEARCH;
         rx_valid    <= 1'b0;
         rx_x        <= '0;
         rx_y        <= '0;
         rx_r        <= '0;
         rx_g        <= '0;
         rx_b        <= '0;
         frame_start <= 1'b0;
         locked      <= 1'b0;
         sync_err    <= 1'b0;
      end else begin
         rx_valid    <= 1'b0;
         frame_start <= 1'b0;
         sync_err    <= 1'b0;
         if (pix_en) begin
            r_prev_h    <= h_sync;
            r_prev_v    <= v_sync;
            r_h_count   <= w_h_next;
            r_v_count   <= w_v_next;
            r_good_cnt  <= w_good_next;
            r_state     <= w_state_next;
            locked      <= (w_state_next == S_LOCKED);
            frame_start <= w_fs;
            sync_err    <= w_serr;
            rx_valid    <= w_valid;
            if (w_valid) begin
               rx_x <= w_h_next - c_h_act_start;
               rx_y <= w_v_next - c_v_act_start;
               rx_r <= vga_r;
               rx_g <= vga_g;
               rx_b <= vga_b;
            end
         end
      end
   end

endmodule
`default_nettype wire
